inst_rom_arbiter: RTL

//  Shares the single combinational instruction ROM read port between two requesters:
//  - IF: the instruction-fetch stage.
//  - LS: the load/store unit, for PC-relative constant loads from ROM.

---
 rtl/inst_rom_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/inst_rom_arbiter.sv
// Round-robin arbiter sharing one combinational instruction ROM read port between
// the fetch stage (IF) and the load/store unit (LS), with a registered one-deep response slot.
module inst_rom_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              if_flush,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  output logic              ls_rsp_valid,
  input  logic              ls_rsp_ready,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ls_rsp_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  typedef enum logic {S_IDLE, S_RESP} state_t;
  typedef enum logic {G_IF, G_LS} grant_t;

  state_t              r_state;
  grant_t              r_owner;
  grant_t              r_last_grant;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic                r_if_rsp_valid;
  logic [DATA_W-1:0]   r_if_rsp_data;
  logic                r_if_rsp_err;
  logic                r_ls_rsp_valid;
  logic [DATA_W-1:0]   r_ls_rsp_data;
  logic                r_ls_rsp_err;

  logic w_if_elig;
  logic w_ls_elig;
  logic w_slot_free;
  logic w_grant_if;
  logic w_grant_ls;
  logic w_addr_err;

  // A flushed IF response frees the slot immediately so LS can use the flush cycle.
  always_comb begin
    w_if_elig   = if_req_valid & ~if_flush;
    w_ls_elig   = ls_req_valid;
    w_slot_free = (r_state == S_IDLE) ||
                  ((r_owner == G_IF) && ((r_if_rsp_valid && if_rsp_ready) || if_flush)) ||
                  ((r_owner == G_LS) && r_ls_rsp_valid && ls_rsp_ready);
    w_grant_if  = w_slot_free && w_if_elig && (!w_ls_elig || (r_last_grant == G_LS));
    w_grant_ls  = w_slot_free && w_ls_elig && (!w_if_elig || (r_last_grant == G_IF));
    if (w_grant_if) begin
      rom_addr = if_req_addr;
    end else if (w_grant_ls) begin
      rom_addr = ls_req_addr;
    end else begin
      rom_addr = r_rom_addr;
    end
    w_addr_err = (rom_addr[1:0] != 2'b00);
  end

  assign if_req_ready = w_grant_if;
  assign ls_req_ready = w_grant_ls;
  assign if_rsp_valid = r_if_rsp_valid;
  assign if_rsp_data  = r_if_rsp_data;
  assign if_rsp_err   = r_if_rsp_err;
  assign ls_rsp_valid = r_ls_rsp_valid;
  assign ls_rsp_data  = r_ls_rsp_data;
  assign ls_rsp_err   = r_ls_rsp_err;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state        <= S_IDLE;
      r_owner        <= G_IF;
      r_last_grant   <= G_LS;
      r_rom_addr     <= '0;
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_if_rsp_err   <= 1'b0;
      r_ls_rsp_valid <= 1'b0;
      r_ls_rsp_data  <= '0;
      r_ls_rsp_err   <= 1'b0;
    end else begin
      if (r_if_rsp_valid && (if_rsp_ready || if_flush)) begin
        r_if_rsp_valid <= 1'b0;
      end
      if (r_ls_rsp_valid && ls_rsp_ready) begin
        r_ls_rsp_valid <= 1'b0;
      end

      // Round-robin pointer only moves when both sides actually competed.
      if ((w_grant_if || w_grant_ls) && w_if_elig && w_ls_elig) begin
        r_last_grant <= w_grant_if ? G_IF : G_LS;
      end

      if (w_grant_if) begin
        r_rom_addr     <= rom_addr;
        r_if_rsp_valid <= 1'b1;
        r_if_rsp_data  <= rom_inst;
        r_if_rsp_err   <= w_addr_err;
        r_state        <= S_RESP;
        r_owner        <= G_IF;
      end else if (w_grant_ls) begin
        r_rom_addr     <= rom_addr;
        r_ls_rsp_valid <= 1'b1;
        r_ls_rsp_data  <= rom_inst;
        r_ls_rsp_err   <= w_addr_err;
        r_state        <= S_RESP;
        r_owner        <= G_LS;
      end else if (w_slot_free) begin
        r_state <= S_IDLE;
      end
    end
  end

endmodule
